xcore_if_bpu: RTL and testbench
===============================

# xcore_if_bpu

Dynamic branch prediction unit for the Xcore fetch stage. Predicts the direction and target of each fetched PC using a bimodal table of 2-bit saturating counters and a direct-mapped, tagged branch target buffer (BTB). Produces the registered per-instruction prediction and the `skip` tag that travels down the pipeline to the mem-stage branch/jump unit. Retrains from that unit's resolved outcome.

## Interface
Parameters:
- `BHT_ENTRIES`, 64: counter table depth; power of 2, ≥ 4.
- `BTB_ENTRIES`, 16: BTB depth; power of 2, ≤ `BHT_ENTRIES`.

Clock and reset:
- Single clock `i_clk`.
- Reset `i_rst_n` is asynchronous and active-low.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: async active-low reset.
- `i_if_valid` in 1: fetch PC valid this cycle.
- `i_if_pc` in 32: fetch PC, word aligned.
- `i_if_stall` in 1: hold the prediction register.
- `i_if_flush` in 1: kill the prediction register contents.
- `o_bp_valid` out 1: prediction register holds a live entry.
- `o_bp_pc` out 32: PC the prediction belongs to.
- `o_bp_taken` out 1: predicted taken.
- `o_bp_target` out 32: predicted target; equals `o_bp_pc + 4` when not taken.
- `o_bp_skip` out 2: `2'b01` when predicted taken, `2'b00` otherwise; pipelined to the branch/jump unit as `instr_skip`.
- `i_upd_valid` in 1: resolved conditional branch or jump this cycle.
- `i_upd_pc` in 32: PC of the resolved instruction.
- `i_upd_taken` in 1: actual direction.
- `i_upd_target` in 32: actual taken target (the ALU result).

## Operation
Indexing:
- BHT index = `pc[log2(BHT_ENTRIES)+1:2]`.
- BTB index = `pc[log2(BTB_ENTRIES)+1:2]`.
- BTB tag = `pc[31:log2(BTB_ENTRIES)+2]`.
- BTB entry = {valid, tag, target[31:0]}.

Lookup (combinational on `i_if_pc`):
- `hit` = entry valid and tag match.
- Predicted taken = `counter[1] & hit`.
- Target = BTB target when taken, else `pc + 4`. The add is 32-bit and wraps modulo 2^32.

Prediction register:
- `i_if_flush` = 1: `o_bp_valid` ← 0. Flush has priority over stall and over load.
- Else `i_if_stall` = 1: all outputs hold.
- Else: load `{i_if_valid, i_if_pc, taken, target, skip}`.
- When `o_bp_valid` = 0, `o_bp_taken` and `o_bp_skip` read 0.

Update (on the clock edge where `i_upd_valid` = 1):
- Counter at BHT index: +1 saturating at `2'b11` if taken; −1 saturating at `2'b00` if not taken.
- If taken: write BTB entry {1, tag, `i_upd_target`}. This replaces any previous occupant.
- If not taken: BTB untouched.
- Updates are independent of `i_if_stall` and `i_if_flush`.

Read/write collision:
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update value. No bypass.

Reset (asynchronous, at any time including mid-update):
- All counters ← `2'b01` (weakly not-taken).
- All BTB valid bits ← 0.
- `o_bp_valid` ← 0, `o_bp_pc` ← 0, `o_bp_taken` ← 0, `o_bp_target` ← 0, `o_bp_skip` ← 0.
- Tag and target storage need not be reset.

## Timing
- Lookup latency: 1 cycle. A PC presented in cycle N with no stall or flush appears on outputs after the edge ending cycle N.
- Update visibility: a write at edge E is visible to lookups presented in the cycle after E.
- Throughput: one lookup and one update per cycle, concurrently.
- Stall: an unbounded stall holds the outputs bit-stable.
- No handshakes. The fetch stage owns PC redirection using `o_bp_taken` / `o_bp_target`.

## Test plan
- Reset/cold start: release reset; fetch 0x100 → next cycle `o_bp_valid`=1, `o_bp_taken`=0, `o_bp_target`=0x104, `o_bp_skip`=00.
- Single training: update {pc 0x100, taken, target 0x200}; next cycle fetch 0x100 → `taken`=1, `target`=0x200, `skip`=01. Then update not-taken; fetch 0x100 → `taken`=0, `target`=0x104.
- Saturation: three taken updates at 0x100 (counter 11); one not-taken (counter 10) → still predicts taken; a second not-taken (counter 01) → not taken.
- BTB alias (default params): train 0x100 taken → 0x200; fetch 0x140 (same BTB index, different tag) → not taken. Then train 0x140 taken → 0x300; fetch 0x100 → BTB miss, not taken.
- Stall/flush: assert stall with a live taken prediction for 3 cycles → outputs constant. Assert flush and stall together → `o_bp_valid`=0, `o_bp_taken`=0, `o_bp_skip`=00.
- Collision and async reset: same-cycle fetch and taken update of untrained 0x100 → not taken; the following fetch → taken. Assert `i_rst_n` low mid-cycle during an update → outputs clear immediately; after release, fetch 0x100 → not taken.

Source files
------------

// File: rtl/xcore_if_bpu.sv
// Fetch-stage branch predictor: bimodal 2-bit counters plus a direct-mapped tagged BTB.
// One registered prediction per fetched PC; retrained from the mem-stage branch/jump unit.
module xcore_if_bpu #(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_valid,
    input  logic [31:0] i_if_pc,
    input  logic        i_if_stall,
    input  logic        i_if_flush,
    output logic        o_bp_valid,
    output logic [31:0] o_bp_pc,
    output logic        o_bp_taken,
    output logic [31:0] o_bp_target,
    output logic [1:0]  o_bp_skip,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target
);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = 30 - BTB_IW;

    logic [1:0]             bht     [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_vld;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [31:0]            btb_tgt [BTB_ENTRIES];

    logic [BHT_IW-1:0] if_bht_idx, upd_bht_idx;
    logic [BTB_IW-1:0] if_btb_idx, upd_btb_idx;
    logic [TAG_W-1:0]  if_tag, upd_tag;
    logic              hit, pred_taken;
    logic [31:0]       pred_target;
    logic [1:0]        cnt, cnt_nxt;
    logic              unused_pc_lsbs;

    assign if_bht_idx  = i_if_pc[BHT_IW+1:2];
    assign if_btb_idx  = i_if_pc[BTB_IW+1:2];
    assign if_tag      = i_if_pc[31:BTB_IW+2];
    assign upd_bht_idx = i_upd_pc[BHT_IW+1:2];
    assign upd_btb_idx = i_upd_pc[BTB_IW+1:2];
    assign upd_tag     = i_upd_pc[31:BTB_IW+2];
    assign unused_pc_lsbs = ^{i_if_pc[1:0], i_upd_pc[1:0]};

    // Lookup reads storage directly, so a same-cycle update is not visible until next cycle.
    assign hit         = btb_vld[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
    assign pred_taken  = bht[if_bht_idx][1] & hit;
    assign pred_target = pred_taken ? btb_tgt[if_btb_idx] : i_if_pc + 32'd4;

    always_comb begin
        cnt     = bht[upd_bht_idx];
        cnt_nxt = cnt;
        if (i_upd_taken) begin
            if (cnt != 2'b11) cnt_nxt = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) cnt_nxt = cnt - 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
            btb_vld <= '0;
        end else if (i_upd_valid) begin
            bht[upd_bht_idx] <= cnt_nxt;
            if (i_upd_taken) btb_vld[upd_btb_idx] <= 1'b1;
        end
    end

    // Tag/target payload is qualified by btb_vld, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (i_upd_valid && i_upd_taken) begin
            btb_tag[upd_btb_idx] <= upd_tag;
            btb_tgt[upd_btb_idx] <= i_upd_target;
        end
    end

    logic        vld_q, taken_q;
    logic [31:0] pc_q, target_q;
    logic [1:0]  skip_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q    <= 1'b0;
            pc_q     <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
            skip_q   <= 2'b00;
        end else if (i_if_flush) begin
            vld_q   <= 1'b0;
            taken_q <= 1'b0;
            skip_q  <= 2'b00;
        end else if (!i_if_stall) begin
            vld_q    <= i_if_valid;
            pc_q     <= i_if_pc;
            taken_q  <= pred_taken;
            target_q <= pred_target;
            skip_q   <= {1'b0, pred_taken};
        end
    end

    assign o_bp_valid  = vld_q;
    assign o_bp_pc     = pc_q;
    assign o_bp_target = target_q;
    assign o_bp_taken  = taken_q & vld_q;
    assign o_bp_skip   = vld_q ? skip_q : 2'b00;

endmodule

// File: tb/tb_xcore_if_bpu.sv
// Directed bench for xcore_if_bpu: cold start, training, saturation, BTB aliasing,
// stall/flush, lookup/update collision and asynchronous reset.
module tb_xcore_if_bpu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_stall, if_flush;
    logic [31:0] if_pc;
    logic        bp_valid, bp_taken;
    logic [31:0] bp_pc, bp_target;
    logic [1:0]  bp_skip;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc, upd_target;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    xcore_if_bpu dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_valid(if_valid), .i_if_pc(if_pc), .i_if_stall(if_stall), .i_if_flush(if_flush),
        .o_bp_valid(bp_valid), .o_bp_pc(bp_pc), .o_bp_taken(bp_taken),
        .o_bp_target(bp_target), .o_bp_skip(bp_skip),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tgt, input logic [1:0] sk);
        chk({tag, ".valid"},  {31'd0, bp_valid}, {31'd0, v});
        chk({tag, ".pc"},     bp_pc, pc);
        chk({tag, ".taken"},  {31'd0, bp_taken}, {31'd0, tk});
        chk({tag, ".target"}, bp_target, tgt);
        chk({tag, ".skip"},   {30'd0, bp_skip}, {30'd0, sk});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; upd_valid = 1'b0; if_stall = 1'b0; if_flush = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        idle();
        if_valid = 1'b1; if_pc = pc;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        idle();
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; idle();
        if_pc = '0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        #12;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
        rst_n = 1'b1;
        tick();

        // Cold start and single training
        fetch(32'h100);
        chk_out("cold", 1'b1, 32'h100, 1'b0, 32'h104, 2'b00);
        train(32'h100, 1'b1, 32'h200);
        fetch(32'h100);
        chk_out("train_t", 1'b1, 32'h100, 1'b1, 32'h200, 2'b01);
        train(32'h100, 1'b0, 32'h0);
        fetch(32'h100);
        chk_out("train_nt", 1'b1, 32'h100, 1'b0, 32'h104, 2'b00);

        // Saturation: 01 -> 11 (saturates), 10 still taken, 01 not taken
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        fetch(32'h100);
        chk_out("sat_10", 1'b1, 32'h100, 1'b1, 32'h200, 2'b01);
        train(32'h100, 1'b0, 32'h0);
        fetch(32'h100);
        chk_out("sat_01", 1'b1, 32'h100, 1'b0, 32'h104, 2'b00);

        // BTB alias: 0x100 and 0x140 share BTB slot 0, differ in tag
        train(32'h100, 1'b1, 32'h200);
        fetch(32'h140);
        chk_out("alias_140", 1'b1, 32'h140, 1'b0, 32'h144, 2'b00);
        train(32'h140, 1'b1, 32'h300);
        fetch(32'h100);
        chk_out("alias_100_miss", 1'b1, 32'h100, 1'b0, 32'h104, 2'b00);
        fetch(32'h140);
        chk_out("alias_140_hit", 1'b1, 32'h140, 1'b1, 32'h300, 2'b01);

        // Stall holds a live taken prediction while the fetch PC moves
        idle();
        if_stall = 1'b1; if_valid = 1'b1; if_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 1'b1, 32'h140, 1'b1, 32'h300, 2'b01);
        end
        if_flush = 1'b1;
        tick();
        chk("flush.valid", {31'd0, bp_valid}, 32'd0);
        chk("flush.taken", {31'd0, bp_taken}, 32'd0);
        chk("flush.skip",  {30'd0, bp_skip},  32'd0);
        idle();

        // Same-cycle lookup and update of an untrained PC sees pre-update state
        do_reset();
        idle();
        if_valid = 1'b1; if_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
        tick();
        chk_out("collide", 1'b1, 32'h100, 1'b0, 32'h104, 2'b00);
        fetch(32'h100);
        chk_out("collide_next", 1'b1, 32'h100, 1'b1, 32'h200, 2'b01);

        // Async reset asserted mid-cycle during an update clears outputs immediately
        idle();
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 2'b00);
        tick();
        upd_valid = 1'b0;
        rst_n = 1'b1;
        fetch(32'h100);
        chk_out("post_rst", 1'b1, 32'h100, 1'b0, 32'h104, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
